// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count detection, one-shot or periodic reload.
// Terminal is detected at 1 so the count never wraps below zero.
module countdown_timer #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             mode,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             expired
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);

   state_t           state_r;
   state_t           next_state_s;
   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] next_count_s;
   logic [WIDTH-1:0] reload_r;
   logic [WIDTH-1:0] next_reload_s;
   logic             expired_r;
   logic             next_expired_s;
   logic             busy_r;

   // State, count, reload and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         count_r   <= ZERO_C;
         reload_r  <= ZERO_C;
         expired_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         count_r   <= next_count_s;
         reload_r  <= next_reload_s;
         expired_r <= next_expired_s;
         busy_r    <= (next_state_s == RUN);
      end
   end

   // Next-state logic: load > stop > decrement/expiry > hold.
   always_comb begin
      next_state_s   = state_r;
      next_count_s   = count_r;
      next_reload_s  = reload_r;
      next_expired_s = 1'b0;

      if (load) begin
         next_reload_s = load_value;
         if (load_value != ZERO_C) begin
            next_count_s = load_value;
            next_state_s = RUN;
         end else begin
            // Zero load expires immediately without entering RUN.
            next_count_s   = ZERO_C;
            next_state_s   = IDLE;
            next_expired_s = 1'b1;
         end
      end else if (stop) begin
         next_state_s = IDLE;
      end else begin
         case (state_r)
            RUN: begin
               if (enable) begin
                  if (count_r == ONE_C) begin
                     next_expired_s = 1'b1;
                     if (mode) begin
                        next_count_s = reload_r;
                     end else begin
                        next_count_s = ZERO_C;
                        next_state_s = IDLE;
                     end
                  end else begin
                     next_count_s = count_r - ONE_C;
                  end
               end else begin
                  next_count_s = count_r;
               end
            end
            IDLE: begin
               next_state_s = IDLE;
            end
            default: begin
               next_state_s = IDLE;
            end
         endcase
      end
   end

   assign count   = count_r;
   assign busy    = busy_r;
   assign expired = expired_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus randomized
// traffic compared against a behavioural model held in plain integers.
module tb_countdown_timer;

   logic       clk;
   logic       reset;
   logic       load;
   logic [4:0] load_value;
   logic       enable;
   logic       mode;
   logic       stop;
   logic [4:0] count;
   logic       busy;
   logic       expired;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state.
   int m_count  = 0;
   int m_reload = 0;
   bit m_run    = 1'b0;
   bit m_exp    = 1'b0;

   countdown_timer #(.WIDTH(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .enable     (enable),
      .mode       (mode),
      .stop       (stop),
      .count      (count),
      .busy       (busy),
      .expired    (expired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_count  = 0;
      m_reload = 0;
      m_run    = 1'b0;
      m_exp    = 1'b0;
   endtask

   // One clock edge of the timer's rules, evaluated with integer arithmetic.
   task automatic model_step(input bit ld, input int lv, input bit en, input bit md, input bit st);
      if (ld) begin
         m_reload = lv;
         m_count  = lv;
         m_run    = (lv != 0);
         m_exp    = (lv == 0);
      end else if (st) begin
         m_run = 1'b0;
         m_exp = 1'b0;
      end else if (m_run && en) begin
         m_count = m_count - 1;
         m_exp   = (m_count == 0);
         if (m_exp) begin
            m_count = md ? m_reload : 0;
            m_run   = md;
         end
      end else begin
         m_exp = 1'b0;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_count"},   32'(count),   32'(m_count));
      chk({tag, "_busy"},    32'(busy),    32'(m_run));
      chk({tag, "_expired"}, 32'(expired), 32'(m_exp));
   endtask

   task automatic cycle(input bit ld, input int lv, input bit en, input bit md, input bit st);
      load       = ld;
      load_value = 5'(lv);
      enable     = en;
      mode       = md;
      stop       = st;
      @(posedge clk);
      model_step(ld, lv, en, md, st);
      #1;
      check_model("cyc");
   endtask

   // Asserts reset between edges and checks outputs clear before the next edge.
   task automatic async_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk({tag, "_rst_count"},   32'(count),   32'd0);
      chk({tag, "_rst_busy"},    32'(busy),    32'd0);
      chk({tag, "_rst_expired"}, 32'(expired), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int lat;
      int pulses;
      reset      = 1'b1;
      load       = 1'b0;
      load_value = 5'd0;
      enable     = 1'b0;
      mode       = 1'b0;
      stop       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_count",   32'(count),   32'd0);
      chk("reset_busy",    32'(busy),    32'd0);
      chk("reset_expired", 32'(expired), 32'd0);
      reset = 1'b0;
      model_reset();

      // One-shot load 5.
      cycle(1'b1, 5, 1'b1, 1'b0, 1'b0);
      chk("os5_c0", 32'(count), 32'd5);
      for (int i = 1; i <= 7; i++) begin
         cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
         chk("os5_count",   32'(count),   32'((i <= 5) ? 5 - i : 0));
         chk("os5_expired", 32'(expired), 32'(i == 5));
         chk("os5_busy",    32'(busy),    32'(i < 5));
      end

      // Periodic load 3.
      cycle(1'b1, 3, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
         chk("per3_count",   32'(count),   32'(3 - (i % 3)));
         chk("per3_expired", 32'(expired), 32'((i % 3) == 0));
         chk("per3_busy",    32'(busy),    32'd1);
      end

      // Enable gaps stretch the countdown.
      cycle(1'b1, 4, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk("gap_hold", 32'(count), 32'd3);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      chk("gap_end_count",   32'(count),   32'd0);
      chk("gap_end_expired", 32'(expired), 32'd1);

      // Mid-run reload, then stop.
      pulses = 0;
      cycle(1'b1, 10, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
         pulses += int'(expired);
      end
      chk("mid_count7", 32'(count), 32'd7);
      cycle(1'b1, 2, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
         pulses += int'(expired);
      end
      chk("mid_pulses", 32'(pulses), 32'd1);
      cycle(1'b1, 8, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
      chk("stop_count",   32'(count),   32'd5);
      chk("stop_busy",    32'(busy),    32'd0);
      chk("stop_expired", 32'(expired), 32'd0);
      cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
      chk("stop_idle_hold", 32'(count), 32'd5);

      // Zero load expires at once without going busy.
      cycle(1'b1, 0, 1'b1, 1'b0, 1'b0);
      chk("zero_expired", 32'(expired), 32'd1);
      chk("zero_busy",    32'(busy),    32'd0);
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      chk("zero_pulse_end", 32'(expired), 32'd0);

      // Maximum load; expiry bounded to 40 cycles.
      lat = 0;
      pulses = 0;
      cycle(1'b1, 31, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 40; i++) begin
         cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
         if (expired === 1'b1) begin
            pulses++;
            if (lat == 0) lat = i;
         end
      end
      chk("max_latency", 32'(lat),    32'd31);
      chk("max_pulses",  32'(pulses), 32'd1);

      // Load beats stop.
      cycle(1'b1, 6, 1'b1, 1'b0, 1'b1);
      chk("load_stop_busy",  32'(busy),  32'd1);
      chk("load_stop_count", 32'(count), 32'd6);

      // Asynchronous reset mid-count; stays idle afterwards.
      cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
      async_reset("mid");
      cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
      chk("post_reset_busy", 32'(busy), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         bit ld;
         bit st;
         ld = ($urandom_range(0, 9) == 0);
         st = ($urandom_range(0, 19) == 0);
         cycle(ld, int'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
               bit'($urandom_range(0, 1)), st);
         if ($urandom_range(0, 149) == 0) async_reset("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counter with terminal-count detection. It is the decrementing counterpart of the free-running up-counter used elsewhere in the samples.
- Software or a testbench loads a start value and enables counting.
- The block counts down to zero and raises a one-cycle expiry pulse.
- In periodic mode it reloads automatically.
- Used as a timeout or tick generator next to the up-counter samples.

Parameters:
WIDTH, 5, bit width of count, load_value and the internal reload register

Ports:
clk  input  1  rising-edge clock; the only clock
reset  input  1  asynchronous, active-high reset
load  input  1  when high at a clk edge, latches load_value and (re)starts
load_value  input  WIDTH  start value, also used as the periodic reload value
enable  input  1  decrement permitted this cycle; when low, count holds
mode  input  1  0 = one-shot, 1 = periodic; sampled every cycle while running
stop  input  1  abort: return to IDLE and hold the current count
count  output  WIDTH  current counter value (registered)
busy  output  1  high while in RUN state (registered)
expired  output  1  one-cycle pulse when the count reaches terminal (registered)

Behaviour:
- Interface: single clock clk; reset is asynchronous and active-high.
- Reset (asynchronous, takes effect immediately):
  - count=0, busy=0, expired=0, reload register=0, state=IDLE.
  - Deassertion is synchronous to clk; first functional edge is the one after deassertion.
- States: IDLE and RUN. busy=1 exactly when state==RUN.
- Priority per edge: reset > load > stop > decrement/expiry > hold.
- load=1 (any state):
  - reload register <= load_value.
  - If load_value!=0: count <= load_value, state <= RUN, expired <= 0.
  - If load_value==0: count <= 0, state <= IDLE, expired <= 1 (immediate expiry, one cycle).
  - A load in RUN discards the in-progress countdown; no expiry pulse for the discarded run.
- stop=1 with load=0: state <= IDLE, count holds, expired <= 0.
- RUN, enable=1, count>1: count <= count-1, expired <= 0.
- RUN, enable=1, count==1 (terminal) sets expired <= 1, then:
  - mode=0: count <= 0, state <= IDLE.
  - mode=1: count <= reload register, state stays RUN.
  - Periodic period is therefore exactly reload-value enabled cycles.
- RUN, enable=0: count and state hold, expired <= 0.
- IDLE without load: count holds, expired <= 0. enable and mode are ignored.
- expired is never high for two consecutive cycles, except periodic with reload=1. In that case it is high every enabled cycle.
- Arithmetic: count is unsigned WIDTH bits.
  - The decrement never underflows, because terminal is detected at 1.
  - Reaching count==0 from RUN is only possible via terminal in one-shot mode.
  - Maximum load 2^WIDTH-1 (31 at default) is legal.
- Latency (N = load_value, enable held high):
  - Load sampled at edge E gives count==N, busy==1 after E.
  - expired is high after edge E+N, with count==0 (one-shot) or count==N (periodic).
- Reset asserted mid-run: outputs clear immediately, no expiry pulse. After release the block stays IDLE until the next load.

Test Plan:
- Reset, then load=1 with load_value=5, mode=0, enable=1 held -> count 5,4,3,2,1,0 on successive edges; expired high only on the edge where count becomes 0; busy falls with it; count stays 0 afterwards.
- load_value=3, mode=1, enable=1 for 10 cycles -> count 3,2,1,3,2,1,3,...; expired high on every 3rd edge after the load; busy stays 1.
- load_value=4, enable toggled 1,0,0,1,1,1 -> count 4,3,3,3,2,1,0; expiry is delayed by exactly the two disabled cycles.
- Mid-run load: load 10, run 3 cycles (count 7), load 2 -> count 2,1,0; one expired pulse total. Then stop during a run at count 5 -> busy 0, count holds 5, no expired pulse.
- Edge cases:
  - load_value=0 -> expired pulses one cycle, busy stays 0.
  - load_value=31 -> expires after 31 enabled cycles.
  - load and stop asserted together -> load wins, busy=1.
  - reset asserted asynchronously mid-count -> count=0, busy=0, expired=0 before the next clk edge.
